fetch_queue: RTL and testbench

- Parametrised successor to the single-entry fetch stage.
- Streams instructions from a synchronous instruction BRAM (1-cycle read latency) at one per cycle, with static next-PC prediction from predecoded returning data.
- Buffers fetched {pc, inst, prediction} in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Execute flushes the queue and the in-flight read via a redirect port.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_predecode.sv | 66 ++++++
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue: predecode opcode fields,
// prediction classes and the queue entry layout.
// Optional feature macro: FETCH_JR_PREDICT_EN (JR/JALR target prediction).
package fetch_pkg;

  localparam logic [4:0] OP_J       = 5'b00001;
  localparam logic [5:0] OP_BC      = 6'b110010;
  localparam logic [4:0] OP_BEQ_BNE = 5'b00010;
  localparam logic [5:0] FUNCT_JR   = 6'b001001;

  typedef enum logic [2:0] {
    PK_SEQ,
    PK_JUMP,
    PK_BC,
    PK_BRANCH,
    PK_JR
  } pred_kind_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] target;
  } fq_entry_t;

endpackage

// File: rtl/fetch_predecode.sv
// Static next-PC predictor applied to an instruction returning from BRAM.
// Purely combinational. JR/JALR prediction from the register file is
// enabled by FETCH_JR_PREDICT_EN.
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [31:0] jr_data,
  output logic        is_jr,
  output logic        taken,
  output logic [31:0] target
);

  pred_kind_t  kind;
  logic [31:0] seq_pc;
  logic [31:0] j_tgt;
  logic [31:0] bc_tgt;
  logic [31:0] br_tgt;

  assign seq_pc = pc + 32'd4;
  assign j_tgt  = {pc[31:28], inst[25:0], 2'b00};
  assign bc_tgt = pc + {{4{inst[25]}}, inst[25:0], 2'b00};
  assign br_tgt = pc + {{14{inst[15]}}, inst[15:0], 2'b00};

`ifdef FETCH_JR_PREDICT_EN
  logic unused_jr_bits;
  assign unused_jr_bits = ^jr_data[1:0];
`else
  logic unused_jr_bits;
  assign unused_jr_bits = ^jr_data;
`endif

  // Classify the instruction in predictor priority order
  always_comb begin
    kind = PK_SEQ;
    if (inst[31:27] == OP_J)
      kind = PK_JUMP;
    else if (inst[31:26] == OP_BC)
      kind = PK_BC;
    else if ((inst[31:27] == OP_BEQ_BNE) && inst[15])
      kind = PK_BRANCH;
    else if ((inst[31:26] == 6'b000000) && (inst[5:0] == FUNCT_JR))
      kind = PK_JR;
  end

  // Select prediction and target for the class
  always_comb begin
    is_jr  = (kind == PK_JR);
    taken  = 1'b0;
    target = seq_pc;
    case (kind)
      PK_JUMP:   begin taken = 1'b1; target = j_tgt;  end
      PK_BC:     begin taken = 1'b1; target = bc_tgt; end
      PK_BRANCH: begin taken = 1'b1; target = br_tgt; end
      PK_JR: begin
`ifdef FETCH_JR_PREDICT_EN
        taken  = 1'b1;
        target = {jr_data[31:2], 2'b00};
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: streams one instruction per cycle from a 1-cycle BRAM,
// predicts the next PC from the returning word and buffers entries in a
// DEPTH-entry circular queue with a registered head for decode.
// Optional feature macro: FETCH_JR_PREDICT_EN (predict JR/JALR targets
// instead of stalling until redirect).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned AW       = 17,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] inst_addr,
  output logic          inst_en,
  input  logic [31:0]   inst_data,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [4:0]    jr_reg,
  input  logic [31:0]   jr_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic          out_pred_taken,
  output logic [31:0]   out_pred_target
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fq_entry_t     mem [DEPTH];
  fq_entry_t     head_q;
  fq_entry_t     new_entry;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_after_deq;
  logic [CW-1:0] count_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_q;
  logic [31:0]   next_pc;
  logic          inflight;
  logic          stall;
  logic          enq;
  logic          deq;
  logic          issue;
  logic          jr_block;
  logic          pd_is_jr;
  logic          pd_taken;
  logic [31:0]   pd_target;

  fetch_predecode u_predecode (
    .pc      (pc_q),
    .inst    (inst_data),
    .jr_data (jr_data),
    .is_jr   (pd_is_jr),
    .taken   (pd_taken),
    .target  (pd_target)
  );

`ifdef FETCH_JR_PREDICT_EN
  logic unused_bits;
  assign jr_reg      = inst_data[20:16];
  assign jr_block    = 1'b0;
  assign unused_bits = ^{redirect_pc[1:0], pd_is_jr};
`else
  // Without JR prediction the word after a JR must never be fetched,
  // so the response cycle itself already blocks issue.
  logic unused_bits;
  assign jr_reg      = '0;
  assign jr_block    = inflight & pd_is_jr;
  assign unused_bits = ^redirect_pc[1:0];
`endif

  // Issue decision, next fetch address and queue occupancy bookkeeping
  always_comb begin
    new_entry.pc     = pc_q;
    new_entry.inst   = inst_data;
    new_entry.taken  = pd_taken;
    new_entry.target = pd_target;
    next_pc          = inflight ? pd_target : fetch_pc;
    enq              = inflight;
    deq              = out_valid & out_ready;
    issue            = ~rst & ~redirect_valid & ~stall & ~jr_block &
                       ((count + CW'(inflight)) < CW'(DEPTH));
    cnt_after_deq    = count - CW'(deq);
    count_next       = cnt_after_deq + CW'(enq);
  end

  assign inst_en         = issue;
  assign inst_addr       = next_pc[AW+1:2];
  assign out_valid       = (count != '0);
  assign out_pc          = head_q.pc;
  assign out_inst        = head_q.inst;
  assign out_pred_taken  = head_q.taken;
  assign out_pred_target = head_q.target;

  // Fetch control, pointers and registered head copy
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      stall    <= 1'b0;
      fetch_pc <= RESET_PC;
      pc_q     <= '0;
      head_q   <= '0;
    end else if (redirect_valid) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      stall    <= 1'b0;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else begin
      count    <= count_next;
      inflight <= issue;
      fetch_pc <= next_pc;
      if (issue)    pc_q   <= next_pc;
      if (deq)      rd_ptr <= rd_ptr + PW'(1);
      if (enq)      wr_ptr <= wr_ptr + PW'(1);
      if (jr_block) stall  <= 1'b1;
      // Head mirrors mem[rd_ptr] one cycle later; when the queue drains to
      // the incoming entry alone, take it straight from the response.
      if (count_next != '0)
        head_q <= (cnt_after_deq == '0) ? new_entry : mem[rd_ptr + PW'(deq)];
    end
  end

  // Queue storage, written on enqueue only
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && enq)
      mem[wr_ptr] <= new_entry;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, all
// checked every cycle against a program-order reference model.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int unsigned AW       = 17;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic        jr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic          valid;
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic          taken;
    logic [31:0]   target;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] inst_addr;
  logic          inst_en;
  logic [31:0]   inst_data = '0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic [4:0]    jr_reg;
  logic [31:0]   jr_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_pred_taken;
  logic [31:0]   out_pred_target;

  logic [31:0] bram [256];
  logic [31:0] regs [32];

  ent_t        mq[$];
  ent_t        m_last = '0;
  logic        m_inflight = 1'b0;
  logic        m_stall = 1'b0;
  logic [31:0] m_pc_q = '0;
  logic [31:0] m_next = RESET_PC;
  logic        c_en;
  logic [31:0] c_pc;
  snap_t       snaps[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  fetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_addr       (inst_addr),
    .inst_en         (inst_en),
    .inst_data       (inst_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .jr_reg          (jr_reg),
    .jr_data         (jr_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM (256 words, aliased) and combinational register file
  always @(posedge clk) if (inst_en) inst_data <= bram[inst_addr[7:0]];
  assign jr_data = regs[jr_reg];

  // Reference predictor, written from the prediction rules with signed arithmetic
  function automatic ent_t predict(input logic [31:0] pc, input logic [31:0] inst);
    ent_t e;
    e.jr = 1'b0; e.pc = pc; e.inst = inst; e.taken = 1'b0; e.target = pc + 32'd4;
    if (inst[31:27] == 5'b00001) begin
      e.taken = 1'b1; e.target = {pc[31:28], inst[25:0], 2'b00};
    end else if (inst[31:26] == 6'b110010) begin
      e.taken = 1'b1; e.target = pc + 32'(4 * int'($signed(inst[25:0])));
    end else if (inst[31:27] == 5'b00010 && inst[15]) begin
      e.taken = 1'b1; e.target = pc + 32'(4 * int'($signed(inst[15:0])));
    end else if (inst[31:26] == 6'd0 && inst[5:0] == 6'b001001) begin
      e.jr = 1'b1;
`ifdef FETCH_JR_PREDICT_EN
      e.taken = 1'b1; e.target = regs[inst[20:16]] & 32'hffff_fffc;
`endif
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model state
  task automatic cycle_check();
    ent_t  r;
    ent_t  h;
    logic  blk;
    snap_t s;
    blk = 1'b0;
    r = '0;
    if (m_inflight) begin
      r = predict(m_pc_q, bram[m_pc_q[9:2]]);
`ifndef FETCH_JR_PREDICT_EN
      blk = r.jr;
`endif
    end
    c_pc = m_inflight ? r.target : m_next;
    c_en = !rst && !redirect_valid && !m_stall && !blk &&
           ((mq.size() + int'(m_inflight)) < DEPTH);
    s.en = inst_en; s.addr = inst_addr; s.valid = out_valid; s.pc = out_pc;
    s.inst = out_inst; s.taken = out_pred_taken; s.target = out_pred_target;
    snaps.push_back(s);
    chk("inst_en", 32'(inst_en), 32'(c_en));
    if (rst) return;
    if (c_en) chk("inst_addr", 32'(inst_addr), 32'(c_pc[AW+1:2]));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    h = (mq.size() != 0) ? mq[0] : m_last;
    chk("out_pc", out_pc, h.pc);
    chk("out_inst", out_inst, h.inst);
    chk("out_pred_taken", 32'(out_pred_taken), 32'(h.taken));
    chk("out_pred_target", out_pred_target, h.target);
  endtask

  // Model update at the clock edge, from this cycle's inputs and decisions
  task automatic model_advance();
    ent_t r;
    if (rst) begin
      mq.delete(); m_inflight = 1'b0; m_stall = 1'b0; m_next = RESET_PC; m_last = '0;
      return;
    end
    if (redirect_valid) begin
      mq.delete(); m_inflight = 1'b0; m_stall = 1'b0;
      m_next = redirect_pc & 32'hffff_fffc;
      return;
    end
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    if (m_inflight) begin
      r = predict(m_pc_q, bram[m_pc_q[9:2]]);
      mq.push_back(r);
`ifndef FETCH_JR_PREDICT_EN
      if (r.jr) m_stall = 1'b1;
`endif
    end
    m_next = c_pc;
    m_inflight = c_en;
    if (c_en) m_pc_q = c_pc;
    if (mq.size() != 0) m_last = mq[0];
  endtask

  task automatic tick(input logic r, input logic rdy, input logic rv, input logic [31:0] rp);
    rst = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rp;
    #1;
    cycle_check();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_bram();
    for (int unsigned i = 0; i < 256; i++) bram[i] = 32'h0;
  endtask

  function automatic int unsigned count_en(input int unsigned from, input int unsigned to);
    int unsigned n;
    n = 0;
    for (int unsigned k = from; k <= to; k++) if (snaps[k].en) n++;
    return n;
  endfunction

  function automatic logic [31:0] rand_inst();
    int unsigned sel;
    logic [31:0] w;
    sel = $urandom_range(0, 99);
    w = $urandom;
    if (sel < 40)      w = {6'b001000, w[25:0]};
    else if (sel < 52) w = {5'b00001, w[26:0]};
    else if (sel < 60) w = {6'b110010, w[25:0]};
    else if (sel < 75) w = {5'b00010, w[26:0]};
    else if (sel < 80) w = {6'b000000, w[25:6], 6'b001001};
    else               w = {6'b000000, w[25:6], 6'b100001};
    return w;
  endfunction

  initial begin
    ent_t e;
    int unsigned b;

    for (int unsigned i = 0; i < 32; i++) regs[i] = $urandom;
    regs[5] = 32'h0000_1007;

    // Pin the reference predictor with hand-computed cases
    e = predict(32'h10, 32'h0800_0040);
    chk("pin_j_taken", 32'(e.taken), 32'd1);
    chk("pin_j_target", e.target, 32'h100);
    e = predict(32'h20, 32'h1022_fffe);
    chk("pin_beq_back_taken", 32'(e.taken), 32'd1);
    chk("pin_beq_back_target", e.target, 32'h18);
    e = predict(32'h20, 32'h14a5_0004);
    chk("pin_bne_fwd_taken", 32'(e.taken), 32'd0);
    chk("pin_bne_fwd_target", e.target, 32'h24);
    e = predict(32'h100, 32'hcbff_ffff);
    chk("pin_bc_target", e.target, 32'hfc);
    e = predict(32'hf000_0000, 32'h0800_0001);
    chk("pin_j_region", e.target, 32'hf000_0004);

    @(negedge clk);

    // A: NOP stream with a J at 0x10 to word 0x40
    clear_bram();
    bram[4] = 32'h0800_0040;
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    b = snaps.size();
    for (int unsigned i = 0; i < 12; i++) tick(0, 1, 0, 0);
    chk("A_rst_valid", 32'(snaps[b].valid), 32'd0);
    chk("A_rst_pc", snaps[b].pc, 32'h0);
    chk("A_first_en", 32'(snaps[b].en), 32'd1);
    chk("A_addr0", 32'(snaps[b].addr), 32'h0);
    chk("A_addr1", 32'(snaps[b+1].addr), 32'h1);
    chk("A_addr2", 32'(snaps[b+2].addr), 32'h2);
    chk("A_valid_c1", 32'(snaps[b+1].valid), 32'd0);
    chk("A_valid_c2", 32'(snaps[b+2].valid), 32'd1);
    chk("A_pc_c2", snaps[b+2].pc, 32'h0);
    chk("A_pc_c3", snaps[b+3].pc, 32'h4);
    chk("A_j_next_addr", 32'(snaps[b+5].addr), 32'h40);
    chk("A_j_taken", 32'(snaps[b+6].taken), 32'd1);
    chk("A_j_target", snaps[b+6].target, 32'h100);
    chk("A_after_j_pc", snaps[b+7].pc, 32'h100);

    // B: forward BNE at 0x1c, backward BEQ at 0x20 looping to 0x18
    clear_bram();
    bram[7] = 32'h14a5_0004;
    bram[8] = 32'h1022_fffe;
    tick(1, 0, 0, 0);
    b = snaps.size();
    for (int unsigned i = 0; i < 14; i++) tick(0, 1, 0, 0);
    chk("B_loop_addr", 32'(snaps[b+9].addr), 32'h6);
    chk("B_fwd_pc", snaps[b+9].pc, 32'h1c);
    chk("B_fwd_taken", 32'(snaps[b+9].taken), 32'd0);
    chk("B_fwd_target", snaps[b+9].target, 32'h20);
    chk("B_back_taken", 32'(snaps[b+10].taken), 32'd1);
    chk("B_back_target", snaps[b+10].target, 32'h18);
    chk("B_loop_pc", snaps[b+11].pc, 32'h18);

    // C: decode stalled, queue fills to DEPTH; one accept frees one issue
    clear_bram();
    tick(1, 0, 0, 0);
    b = snaps.size();
    for (int unsigned i = 0; i < 10; i++) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int unsigned i = 0; i < 6; i++) tick(0, 0, 0, 0);
    chk("C_fill_issues", count_en(b, b + 9), DEPTH);
    chk("C_full_en", 32'(snaps[b+9].en), 32'd0);
    chk("C_full_head", snaps[b+9].pc, 32'h0);
    chk("C_resume_issues", count_en(b + 10, b + 16), 32'd1);
    chk("C_resume_addr", 32'(snaps[b+11].addr), 32'h4);
    chk("C_new_head", snaps[b+11].pc, 32'h4);

    // D: redirect to 0x203 with three queued and one in flight
    tick(1, 0, 0, 0);
    b = snaps.size();
    for (int unsigned i = 0; i < 4; i++) tick(0, 0, 0, 0);
    tick(0, 0, 1, 32'h203);
    for (int unsigned i = 0; i < 4; i++) tick(0, 0, 0, 0);
    chk("D_pre_valid", 32'(snaps[b+4].valid), 32'd1);
    chk("D_redirect_en", 32'(snaps[b+4].en), 32'd0);
    chk("D_flushed", 32'(snaps[b+5].valid), 32'd0);
    chk("D_restart_en", 32'(snaps[b+5].en), 32'd1);
    chk("D_restart_addr", 32'(snaps[b+5].addr), 32'h80);
    chk("D_restart_pc", snaps[b+7].pc, 32'h200);

    // E: JR at 0x30 with register 5 = 0x1007
    clear_bram();
    bram[12] = 32'h00a5_0009;
    tick(1, 0, 0, 0);
    b = snaps.size();
    for (int unsigned i = 0; i < 20; i++) tick(0, 1, 0, 0);
    tick(0, 1, 1, 32'h44);
    for (int unsigned i = 0; i < 3; i++) tick(0, 1, 0, 0);
    chk("E_jr_pc", snaps[b+14].pc, 32'h30);
`ifdef FETCH_JR_PREDICT_EN
    chk("E_jr_next_en", 32'(snaps[b+13].en), 32'd1);
    chk("E_jr_next_addr", 32'(snaps[b+13].addr), 32'h401);
    chk("E_jr_taken", 32'(snaps[b+14].taken), 32'd1);
    chk("E_jr_target", snaps[b+14].target, 32'h1004);
`else
    chk("E_jr_stall", count_en(b + 13, b + 19), 32'd0);
    chk("E_jr_taken", 32'(snaps[b+14].taken), 32'd0);
    chk("E_jr_target", snaps[b+14].target, 32'h34);
`endif
    chk("E_unstall_en", 32'(snaps[b+21].en), 32'd1);
    chk("E_unstall_addr", 32'(snaps[b+21].addr), 32'h11);

    // F: randomized program, backpressure, redirects and resets
    for (int unsigned i = 0; i < 256; i++) bram[i] = rand_inst();
    for (int unsigned i = 0; i < 32; i++) regs[i] = $urandom;
    tick(1, 0, 0, 0);
    for (int unsigned i = 0; i < 3000; i++) begin
      logic r_rst;
      logic r_rdy;
      logic r_rv;
      r_rst = ($urandom_range(0, 299) == 0);
      r_rv  = ($urandom_range(0, 24) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      tick(r_rst, r_rdy, r_rv, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
